// File: rtl/uart_rx_word_if.sv
// Receiver-side bus of uart_rx_word: serial input, acknowledge and the
// received-word outputs. The receiver takes the master modport, and the
// consumer takes the slave modport.
interface uart_rx_word_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  rx;
  logic                  ready_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready;
  logic                  frame_err;
  logic                  overrun;
  logic                  rx_busy;

  modport master (
    input  rx,
    input  ready_clr,
    output data_out,
    output ready,
    output frame_err,
    output overrun,
    output rx_busy
  );

  modport slave (
    output rx,
    output ready_clr,
    input  data_out,
    input  ready,
    input  frame_err,
    input  overrun,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx_word.sv
// uart_rx_word: oversampled receiver for a 24-bit-period frame that carries
// one 16-bit word as two bytes. The fixed 1/0 marker slots are checked, and
// any mismatch is reported through frame_err. The word is delivered with a
// ready/ready_clr handshake and an overrun indication.
module uart_rx_word #(
  parameter int DATA_WIDTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clken,
  uart_rx_word_if.master  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SLOTS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  rx_meta;
  logic                  rx_sync;
  logic [TW-1:0]         tick;
  logic [TW-1:0]         tick_next;
  logic [4:0]            slot;
  logic [4:0]            slot_next;
  logic [7:0]            lo;
  logic [7:0]            lo_next;
  logic [7:0]            hi;
  logic [7:0]            hi_next;
  logic                  frame_bad;
  logic                  frame_bad_next;
  logic [1:0]            slot_chk;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] data_hold;
  logic                  ready_flag;
  logic                  err_flag;
  logic                  overrun_flag;

  // Marker-slot lookup: bit 1 = slot is checked, bit 0 = required level.
  function automatic logic [1:0] slot_check(input logic [4:0] s);
    logic [1:0] r;
    case (s)
      5'd8, 5'd9, 5'd19, 5'd20, 5'd22: r = 2'b11;
      5'd10, 5'd21:                    r = 2'b10;
      default:                         r = 2'b00;
    endcase
    return r;
  endfunction

  assign slot_chk      = slot_check(slot);
  assign word          = {hi, lo};
  assign bus.data_out  = data_hold;
  assign bus.ready     = ready_flag;
  assign bus.frame_err = err_flag;
  assign bus.overrun   = overrun_flag;
  assign bus.rx_busy   = (state != IDLE);

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
    end
  end

  // FSM state, counters and frame assembly registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      tick      <= {TW{1'b0}};
      slot      <= 5'd0;
      lo        <= 8'd0;
      hi        <= 8'd0;
      frame_bad <= 1'b0;
    end else begin
      state     <= state_next;
      tick      <= tick_next;
      slot      <= slot_next;
      lo        <= lo_next;
      hi        <= hi_next;
      frame_bad <= frame_bad_next;
    end
  end

  // Next-state and counter logic. It advances on clken, but DONE always lasts one clk.
  always_comb begin
    state_next     = state;
    tick_next      = tick;
    slot_next      = slot;
    lo_next        = lo;
    hi_next        = hi;
    frame_bad_next = frame_bad;
    case (state)
      IDLE: begin
        if (clken && !rx_sync) begin
          state_next = START;
          tick_next  = {TW{1'b0}};
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (clken) begin
          if (tick == TICK_MID) begin
            if (rx_sync) begin
              // The line went back high by mid start bit, so ignore this low pulse as a glitch.
              state_next = IDLE;
            end else begin
              state_next     = SLOTS;
              slot_next      = 5'd0;
              tick_next      = {TW{1'b0}};
              frame_bad_next = 1'b0;
            end
          end else begin
            tick_next = tick + TW'(1);
          end
        end else begin
          state_next = START;
        end
      end
      SLOTS: begin
        if (clken) begin
          if (tick == TICK_LAST) begin
            tick_next = {TW{1'b0}};
            if (slot <= 5'd7) begin
              lo_next = {rx_sync, lo[7:1]};
            end else if ((slot >= 5'd11) && (slot <= 5'd18)) begin
              hi_next = {rx_sync, hi[7:1]};
            end else begin
              lo_next = lo;
            end
            if (slot_chk[1] && (rx_sync != slot_chk[0])) begin
              frame_bad_next = 1'b1;
            end else begin
              frame_bad_next = frame_bad;
            end
            if (slot == 5'd22) begin
              state_next = DONE;
            end else begin
              slot_next = slot + 5'd1;
            end
          end else begin
            tick_next = tick + TW'(1);
          end
        end else begin
          state_next = SLOTS;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output word and handshake. DONE delivers the word, and ready_clr acknowledges it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_hold    <= {DATA_WIDTH{1'b0}};
      ready_flag   <= 1'b0;
      err_flag     <= 1'b0;
      overrun_flag <= 1'b0;
    end else if (state == DONE) begin
      data_hold    <= word;
      err_flag     <= frame_bad;
      ready_flag   <= 1'b1;
      overrun_flag <= ready_flag && !bus.ready_clr;
    end else if (bus.ready_clr) begin
      ready_flag   <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      ready_flag   <= ready_flag;
      overrun_flag <= overrun_flag;
    end
  end

endmodule
